// File: rtl/conv2d_param_engine.sv
`default_nettype none
// ============================================================================
// Module      : conv2d_param_engine
// Description : Frame-based 2-D convolution engine. Buffers one NxN IFM
//               frame plus a KxK kernel, then issues one output window per
//               cycle through a two-stage multiply / sum pipeline. Supports
//               optional symmetric zero padding and a configurable stride.
// Revision    : 1.0 - initial release
// ============================================================================
module conv2d_param_engine #(
   parameter int DW = 16,
   parameter int N  = 7,
   parameter int K  = 3,
   parameter int S  = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   input  logic [DW-1:0]                 In_IFM,
   input  logic                          weight_valid,
   input  logic [DW-1:0]                 In_Weight,
   input  logic                          pad_en,
   output logic                          busy,
   output logic                          out_valid,
   output logic [2*DW+$clog2(K*K)-1:0]   Out_OFM
);

   localparam int OW    = 2*DW + $clog2(K*K);
   localparam int c_NN  = N*N;
   localparam int c_KK  = K*K;
   localparam int c_P1  = (K-1)/2;
   localparam int c_OD0 = (N - K)/S + 1;
   localparam int c_OD1 = (N + 2*c_P1 - K)/S + 1;
   localparam int c_AW  = (c_NN > 1) ? $clog2(c_NN) : 1;
   localparam int c_WW  = $clog2(c_KK + 1);
   localparam int c_RW  = $clog2(N + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CALC = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [DW-1:0]     r_ifm [c_NN];
   logic [DW-1:0]     r_wt  [c_KK];
   logic [c_AW-1:0]   r_cnt;
   logic [c_WW-1:0]   r_wcnt;
   logic              r_pad;
   logic [c_RW-1:0]   r_row;
   logic [c_RW-1:0]   r_col;

   logic              w_accept;
   logic [c_AW-1:0]   w_wr_idx;
   logic              w_last_beat;
   logic [c_RW-1:0]   w_od;
   logic              w_col_end;
   logic              w_row_end;
   logic              w_last_win;
   logic              w_calc;

   logic [DW-1:0]     w_win  [c_KK];
   logic [2*DW-1:0]   w_prod [c_KK];
   logic [2*DW-1:0]   r_prod [c_KK];
   logic              r_v1;
   logic [OW-1:0]     w_sum;
   logic              r_ov;
   logic [OW-1:0]     r_ofm;

   assign w_calc      = (r_state == ST_CALC);
   assign w_accept    = in_valid && !w_calc;
   // In IDLE the accepted beat is always element 0 of a fresh frame.
   assign w_wr_idx    = (r_state == ST_IDLE) ? '0 : r_cnt;
   assign w_last_beat = (w_wr_idx == c_AW'(c_NN - 1));
   assign w_od        = r_pad ? c_RW'(c_OD1) : c_RW'(c_OD0);
   assign w_col_end   = (r_col == w_od - c_RW'(1));
   assign w_row_end   = (r_row == w_od - c_RW'(1));
   assign w_last_win  = w_calc && w_col_end && w_row_end;

   assign busy        = w_calc;
   assign out_valid   = r_ov;
   assign Out_OFM     = r_ofm;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode: a frame starts on its first beat and calculation
   // ends right after the final window enters the pipeline.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_accept) w_state_nxt = w_last_beat ? ST_CALC : ST_LOAD;
         ST_LOAD: if (w_accept && w_last_beat) w_state_nxt = ST_CALC;
         ST_CALC: if (w_last_win) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // IFM capture, beat counter and per-frame padding mode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < c_NN; i++) r_ifm[i] <= '0;
         r_cnt <= '0;
         r_pad <= 1'b0;
      end else if (w_accept) begin
         r_ifm[w_wr_idx] <= In_IFM;
         r_cnt           <= w_last_beat ? '0 : w_wr_idx + c_AW'(1);
         if (r_state == ST_IDLE) r_pad <= pad_en;
      end
   end

   // Kernel capture; the write pointer saturates so surplus beats are
   // dropped, and rewinds whenever the weight stream pauses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < c_KK; i++) r_wt[i] <= '0;
         r_wcnt <= '0;
      end else if (!weight_valid) begin
         r_wcnt <= '0;
      end else if (!w_calc && (r_wcnt < c_WW'(c_KK))) begin
         r_wt[r_wcnt] <= In_Weight;
         r_wcnt       <= r_wcnt + c_WW'(1);
      end
   end

   // Output window scan in raster order, one window per CALC cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_row <= '0;
         r_col <= '0;
      end else if (w_calc) begin
         if (w_col_end) begin
            r_col <= '0;
            r_row <= w_row_end ? '0 : r_row + c_RW'(1);
         end else begin
            r_col <= r_col + c_RW'(1);
         end
      end
   end

   // Window gather: taps that fall into the padding ring read as zero.
   for (genvar gi = 0; gi < K; gi++) begin : g_ki
      for (genvar gj = 0; gj < K; gj++) begin : g_kj
         int              w_y;
         int              w_x;
         logic            w_in;
         logic [c_AW-1:0] w_idx;

         assign w_y   = int'(r_row) * S + gi - (r_pad ? c_P1 : 0);
         assign w_x   = int'(r_col) * S + gj - (r_pad ? c_P1 : 0);
         assign w_in  = (w_y >= 0) && (w_y < N) && (w_x >= 0) && (w_x < N);
         assign w_idx = c_AW'(w_y * N + w_x);
         assign w_win[gi*K+gj]  = w_in ? r_ifm[w_idx] : '0;
         assign w_prod[gi*K+gj] = (2*DW)'(w_win[gi*K+gj]) * (2*DW)'(r_wt[gi*K+gj]);
      end
   end

   // Stage 1: register all tap products of the current window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v1 <= 1'b0;
         for (int i = 0; i < c_KK; i++) r_prod[i] <= '0;
      end else begin
         r_v1 <= w_calc;
         for (int i = 0; i < c_KK; i++) r_prod[i] <= w_calc ? w_prod[i] : '0;
      end
   end

   // Full-width adder tree over the registered products.
   always_comb begin
      w_sum = '0;
      for (int i = 0; i < c_KK; i++) w_sum = w_sum + OW'(r_prod[i]);
   end

   // Stage 2: register the sum; the data bus is forced to zero when idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ov  <= 1'b0;
         r_ofm <= '0;
      end else begin
         r_ov  <= r_v1;
         r_ofm <= r_v1 ? w_sum : '0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_conv2d_param_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv2d_param_engine
// Description : Scoreboard bench for conv2d_param_engine. Instance A runs
//               stride 1, instance B stride 2. Expected words are queued
//               when a frame is issued; a monitor pops them on out_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv2d_param_engine;

   localparam int DW = 16;
   localparam int N  = 7;
   localparam int K  = 3;
   localparam int OW = 2*DW + $clog2(K*K);

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid_a, weight_valid_a, pad_en_a, busy_a, out_valid_a;
   logic [DW-1:0] ifm_a, wt_a;
   logic [OW-1:0] ofm_a;
   logic          in_valid_b, weight_valid_b, pad_en_b, busy_b, out_valid_b;
   logic [DW-1:0] ifm_b, wt_b;
   logic [OW-1:0] ofm_b;

   logic [OW-1:0] q_a[$];
   logic [OW-1:0] q_b[$];
   int            checks = 0;
   int            errors = 0;

   always #5 clk = ~clk;

   conv2d_param_engine #(.DW(DW), .N(N), .K(K), .S(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .In_IFM(ifm_a),
      .weight_valid(weight_valid_a), .In_Weight(wt_a), .pad_en(pad_en_a),
      .busy(busy_a), .out_valid(out_valid_a), .Out_OFM(ofm_a)
   );

   conv2d_param_engine #(.DW(DW), .N(N), .K(K), .S(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .In_IFM(ifm_b),
      .weight_valid(weight_valid_b), .In_Weight(wt_b), .pad_en(pad_en_b),
      .busy(busy_b), .out_valid(out_valid_b), .Out_OFM(ofm_b)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_in(input bit sel, input logic v, input logic [DW-1:0] d);
      if (sel) begin in_valid_b = v; ifm_b = d; end
      else     begin in_valid_a = v; ifm_a = d; end
   endtask

   task automatic set_w(input bit sel, input logic v, input logic [DW-1:0] d);
      if (sel) begin weight_valid_b = v; wt_b = d; end
      else     begin weight_valid_a = v; wt_a = d; end
   endtask

   task automatic set_pad(input bit sel, input logic p);
      if (sel) pad_en_b = p;
      else     pad_en_a = p;
   endtask

   task automatic push_n(input bit sel, input int n, input logic [OW-1:0] v);
      for (int i = 0; i < n; i++) begin
         if (sel) q_b.push_back(v);
         else     q_a.push_back(v);
      end
   endtask

   // mode 0: ones, 1: element index, 2: all-ones word
   function automatic logic [DW-1:0] ifm_val(input int mode, input int k);
      case (mode)
         0:       return DW'(1);
         1:       return DW'(k);
         default: return {DW{1'b1}};
      endcase
   endfunction

   // mode 0: nine ones, 1: centre tap only, 2: nine max words,
   // 3: twelve beats (nine ones then three sevens)
   task automatic load_w(input bit sel, input int mode);
      int            nb;
      logic [DW-1:0] d;
      nb = (mode == 3) ? 12 : K*K;
      for (int i = 0; i < nb; i++) begin
         case (mode)
            0:       d = DW'(1);
            1:       d = (i == 4) ? DW'(1) : DW'(0);
            2:       d = {DW{1'b1}};
            default: d = (i < 9) ? DW'(1) : DW'(7);
         endcase
         set_w(sel, 1'b1, d);
         @(negedge clk);
      end
      set_w(sel, 1'b0, '0);
      @(negedge clk);
   endtask

   // Called at a negedge; returns at the negedge after the last beat's edge.
   task automatic send_frame(input bit sel, input int mode, input logic pad,
                             input bit gaps, input bit lat);
      for (int k = 0; k < N*N; k++) begin
         if (gaps && k > 0) begin
            int g;
            g = $urandom_range(1, 3);
            repeat (g) begin
               set_in(sel, 1'b0, '0);
               @(negedge clk);
            end
         end
         set_in(sel, 1'b1, ifm_val(mode, k));
         set_pad(sel, (k == 0) ? pad : ~pad);
         @(negedge clk);
      end
      set_in(sel, 1'b0, '0);
      if (lat) begin
         check("latency_e0", out_valid_a, 0);
         @(negedge clk);
         check("latency_e1", out_valid_a, 0);
         @(negedge clk);
         check("latency_e2_first_valid", out_valid_a, 1);
      end
   endtask

   task automatic wait_idle(input bit sel);
      for (int i = 0; i < 200; i++) begin
         if (!(sel ? busy_b : busy_a)) break;
         @(negedge clk);
      end
      check("busy_fall", sel ? busy_b : busy_a, 0);
   endtask

   task automatic drain(input bit sel);
      for (int i = 0; i < 300; i++) begin
         if ((sel ? q_b.size() : q_a.size()) == 0 && !(sel ? busy_b : busy_a)) break;
         @(negedge clk);
      end
      repeat (4) @(negedge clk);
      check(sel ? "b_queue_drained" : "a_queue_drained", sel ? q_b.size() : q_a.size(), 0);
   endtask

   task automatic mon(input bit sel);
      logic          v;
      logic [OW-1:0] o;
      logic [OW-1:0] e;
      v = sel ? out_valid_b : out_valid_a;
      o = sel ? ofm_b : ofm_a;
      if (v) begin
         if ((sel ? q_b.size() : q_a.size()) == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: unexpected output %0d, expected none at %0t",
                     sel ? "b_extra" : "a_extra", o, $time);
         end else begin
            if (sel) e = q_b.pop_front();
            else     e = q_a.pop_front();
            check(sel ? "b_ofm" : "a_ofm", o, e);
         end
      end else begin
         check(sel ? "b_ofm_idle_zero" : "a_ofm_idle_zero", o, 0);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      set_in(0, 1'b0, '0); set_in(1, 1'b0, '0);
      set_w(0, 1'b0, '0);  set_w(1, 1'b0, '0);
      set_pad(0, 1'b0);    set_pad(1, 1'b0);
      fork
         begin
            forever begin
               @(negedge clk);
               if (rst_n) begin
                  mon(0);
                  mon(1);
               end
            end
         end
         begin
            repeat (3) @(negedge clk);
            check("rst_out_valid", out_valid_a, 0);
            check("rst_busy", busy_a, 0);
            check("rst_ofm", ofm_a, 0);
            check("rst_b_out_valid", out_valid_b, 0);
            rst_n = 1'b1;
            @(negedge clk);

            // valid-only frame of ones, then a padded frame started right
            // as busy falls; pad_en flips after the first beat
            load_w(0, 0);
            push_n(0, 25, OW'(9));
            send_frame(0, 0, 1'b0, 1'b0, 1'b1);
            wait_idle(0);
            for (int r = 0; r < 7; r++)
               for (int c = 0; c < 7; c++) begin
                  if ((r == 0 || r == 6) && (c == 0 || c == 6)) push_n(0, 1, OW'(4));
                  else if (r == 0 || r == 6 || c == 0 || c == 6) push_n(0, 1, OW'(6));
                  else push_n(0, 1, OW'(9));
               end
            send_frame(0, 0, 1'b1, 1'b0, 1'b0);
            drain(0);

            // stride 2, centre tap picks odd-row/odd-column pixels
            load_w(1, 1);
            foreach (q_b[i]) q_b.delete(i);
            push_n(1, 1, OW'(8));  push_n(1, 1, OW'(10)); push_n(1, 1, OW'(12));
            push_n(1, 1, OW'(22)); push_n(1, 1, OW'(24)); push_n(1, 1, OW'(26));
            push_n(1, 1, OW'(36)); push_n(1, 1, OW'(38)); push_n(1, 1, OW'(40));
            send_frame(1, 1, 1'b0, 1'b0, 1'b0);
            drain(1);

            // maximum operands: 9 * 65535 * 65535
            load_w(0, 2);
            push_n(0, 25, 36'd38653526025);
            send_frame(0, 2, 1'b0, 1'b0, 1'b0);
            drain(0);

            // gapped IFM stream, twelve weight beats (last three ignored)
            load_w(0, 3);
            push_n(0, 25, OW'(9));
            send_frame(0, 0, 1'b0, 1'b1, 1'b0);
            drain(0);

            // reset asserted mid-CALC, then a clean frame
            push_n(0, 25, OW'(9));
            send_frame(0, 0, 1'b0, 1'b0, 1'b0);
            for (int i = 0; i < 100; i++) begin
               if (q_a.size() <= 20) break;
               @(negedge clk);
            end
            @(posedge clk);
            #1;
            check("pre_reset_valid", out_valid_a, 1);
            #1;
            rst_n = 1'b0;
            #1;
            check("midcalc_rst_out_valid", out_valid_a, 0);
            check("midcalc_rst_ofm", ofm_a, 0);
            check("midcalc_rst_busy", busy_a, 0);
            q_a.delete();
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            load_w(0, 0);
            push_n(0, 25, OW'(9));
            send_frame(0, 0, 1'b0, 1'b0, 1'b0);
            drain(0);

            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
         end
         begin
            #200000;
            errors++;
            $display("FAIL timeout: simulation did not complete, expected finish before 200000");
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
         end
      join_any
   end

endmodule
`default_nettype wire
